// File: rtl/lsu_pkg.sv
// Shared encodings and lane-mask helper for the data-memory load/store unit.
package lsu_pkg;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_ILL = 2'b11;

   typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, RESP} state_e;

   // Byte lanes touched by an access: [3:0] first beat, [7:4] second beat.
   // The upper nibble is non-zero exactly when the access crosses a word boundary.
   function automatic logic [7:0] lane_mask(logic [1:0] off, logic [1:0] size);
      logic [3:0] base;
      case (size)
         SIZE_B:  base = 4'b0001;
         SIZE_H:  base = 4'b0011;
         SIZE_W:  base = 4'b1111;
         default: base = 4'b0000;
      endcase
      return {4'b0000, base} << off;
   endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response and RAM-side signal bundle for the load/store unit.
interface data_mem_lsu_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              req_rw;
   logic [1:0]        req_size;
   logic              req_sign;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   // The LSU itself
   modport slave (
      input  req_valid, req_addr, req_wdata, req_rw, req_size, req_sign, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   // Requester plus RAM, as seen from outside the LSU
   modport master (
      output req_valid, req_addr, req_wdata, req_rw, req_size, req_sign, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_load_extract.sv
// Combinational load formatter: picks the addressed bytes out of up to two RAM
// beats and sign/zero extends them to 32 bits.
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] beat0_i,
   input  logic [31:0] beat1_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   output logic [31:0] data_o
);

   logic [63:0] both;
   logic [31:0] win;

   // Concatenate beats so a word-crossing access becomes a simple byte-shifted window.
   always_comb begin
      both = {beat1_i, beat0_i};
      win  = both[{off_i, 3'b000} +: 32];
      case (size_i)
         SIZE_B:  data_o = {{24{sign_i & win[7]}}, win[7:0]};
         SIZE_H:  data_o = {{16{sign_i & win[15]}}, win[15:0]};
         default: data_o = win;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a word-wide synchronous data RAM. Handles byte-lane
// steering, load extension and splitting of word-crossing accesses into two beats.
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic           clock,
   input  logic           reset,
   data_mem_lsu_if.slave  bus
);

   localparam int unsigned WA_W = ADDR_W - 2;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rw_q, rw_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [DATA_W-1:0] beat0_q, beat0_d;

   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [WA_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic [7:0]        req_mask;
   logic [7:0]        lat_mask;
   logic              split;
   logic [DATA_W-1:0] ext_beat0;
   logic [DATA_W-1:0] load_data;

   // Byte k of the store data lands on lane (off + k) mod 4: a left byte-rotation.
   function automatic logic [31:0] steer(logic [31:0] w, logic [1:0] off);
      logic [31:0] r;
      unique case (off)
         2'd0: r = w;
         2'd1: r = {w[23:0], w[31:24]};
         2'd2: r = {w[15:0], w[31:16]};
         2'd3: r = {w[7:0],  w[31:8]};
      endcase
      return r;
   endfunction

   assign req_mask  = lane_mask(bus.req_addr[1:0], bus.req_size);
   assign lat_mask  = lane_mask(addr_q[1:0], size_q);
   assign split     = |lat_mask[7:4];
   // Single-beat loads complete from the live RAM output; split loads use the held first beat.
   assign ext_beat0 = split ? beat0_q : bus.mem_rdata;

   lsu_load_extract u_extract (
      .beat0_i (ext_beat0),
      .beat1_i (bus.mem_rdata),
      .off_i   (addr_q[1:0]),
      .size_i  (size_q),
      .sign_i  (sign_q),
      .data_o  (load_data)
   );

   // Next-state and registered-output computation for the whole access sequence.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rw_d        = rw_q;
      size_d      = size_q;
      sign_d      = sign_q;
      beat0_d     = beat0_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rw_d    = bus.req_rw;
               size_d  = bus.req_size;
               sign_d  = bus.req_sign;
               if (bus.req_size == SIZE_ILL) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  // First beat is issued straight from the request so it appears the next cycle.
                  state_d     = BEAT0;
                  mem_en_d    = 1'b1;
                  mem_we_d    = bus.req_rw;
                  mem_addr_d  = bus.req_addr[ADDR_W-1:2];
                  mem_be_d    = req_mask[3:0];
                  mem_wdata_d = steer(bus.req_wdata, bus.req_addr[1:0]);
               end
            end
         end
         BEAT0: begin
            if (split) begin
               state_d     = BEAT1;
               mem_en_d    = 1'b1;
               mem_we_d    = rw_q;
               mem_addr_d  = addr_q[ADDR_W-1:2] + WA_W'(1);
               mem_be_d    = lat_mask[7:4];
               mem_wdata_d = steer(wdata_q, addr_q[1:0]);
            end else begin
               state_d = WAIT;
            end
         end
         BEAT1: begin
            beat0_d = bus.mem_rdata;
            state_d = WAIT;
         end
         WAIT: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rw_q ? '0 : load_data;
            state_d     = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rw_q        <= 1'b0;
         size_q      <= SIZE_B;
         sign_q      <= 1'b0;
         beat0_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rw_q        <= rw_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         beat0_q     <= beat0_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
